// File: rtl/game_vga_capture_pkg.sv
// Shared VGA capture definitions: FSM encoding and the frame/line total helper.
// Default H_TOTAL/V_TOTAL match the 640x480 timing produced by game_hvsync.
package game_vga_capture_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } cap_state_e;

    function automatic int timing_total(input int active, input int porch_a,
                                        input int sync, input int porch_b);
        return active + porch_a + sync + porch_b;
    endfunction

    localparam int H_TOTAL = timing_total(640, 16, 96, 48);
    localparam int V_TOTAL = timing_total(480, 10, 2, 33);

endpackage

// File: rtl/game_sync_checker.sv
// Deassert-edge detector plus period and low-width measurement for one sync line.
// tick is the measurement unit: every clock for hsync, every line start for vsync.
module game_sync_checker #(
    parameter int CNT_W     = 16,
    parameter int LOW_WIDTH = 0,
    parameter int PERIOD    = 800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_level,
    input  logic tick,
    output logic rise_s,
    output logic fail_s
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LOW_REQ   = CNT_W'(LOW_WIDTH);
    localparam logic [CNT_W-1:0] PER_REQ   = CNT_W'(PERIOD);
    localparam logic             CHECK_LOW = (LOW_WIDTH != 0);

    logic             prev_r;
    logic             per_arm_r;
    logic             low_arm_r;
    logic             fall_s;
    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] low_cnt_r;

    // Edge detection and verdict; a measurement is judged only once fully observed.
    always_comb begin
        rise_s = sync_level & ~prev_r;
        fall_s = ~sync_level & prev_r;
        fail_s = rise_s & ((per_arm_r & (per_cnt_r != PER_REQ)) |
                           (CHECK_LOW & low_arm_r & (low_cnt_r != LOW_REQ)));
    end

    // Period and low-width counters, restarted on their own edges and saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r    <= 1'b1;
            per_arm_r <= 1'b0;
            low_arm_r <= 1'b0;
            per_cnt_r <= {CNT_W{1'b0}};
            low_cnt_r <= {CNT_W{1'b0}};
        end else begin
            prev_r <= sync_level;
            if (rise_s) begin
                per_cnt_r <= {{(CNT_W-1){1'b0}}, tick};
                per_arm_r <= 1'b1;
            end else if (tick && per_cnt_r != CNT_MAX) begin
                per_cnt_r <= per_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (fall_s) begin
                low_cnt_r <= {{(CNT_W-1){1'b0}}, tick};
                low_arm_r <= 1'b1;
            end else if (rise_s) begin
                low_arm_r <= 1'b0;
            end else if (!sync_level && tick && low_cnt_r != CNT_MAX) begin
                low_cnt_r <= low_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/game_vga_capture.sv
// VGA capture: recovers x/y from hsync/vsync, verifies timing and emits pixels once locked.
// Inputs are registered once; outputs are registered from that stage (two-cycle latency).
module game_vga_capture
    import game_vga_capture_pkg::*;
#(
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 10,
    parameter int SCREEN_WIDTH = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int SCREEN_HIGHT = 480,
    parameter int V_BOTTOM     = 10,
    parameter int V_SYNC       = 2,
    parameter int V_TOP        = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [2:0]         rgb,
    output logic               pixel_valid,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic [2:0]         rgb_out,
    output logic               frame_start,
    output logic               locked,
    output logic               error
);

    localparam int H_TOT = timing_total(SCREEN_WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOT = timing_total(SCREEN_HIGHT, V_BOTTOM, V_SYNC, V_TOP);

    localparam logic [X_WIDTH-1:0] H_MAX = {X_WIDTH{1'b1}};
    localparam logic [Y_WIDTH-1:0] V_MAX = {Y_WIDTH{1'b1}};
    localparam logic [X_WIDTH-1:0] H_LO  = X_WIDTH'(H_BACK);
    localparam logic [X_WIDTH-1:0] H_HI  = X_WIDTH'(H_BACK + SCREEN_WIDTH);
    localparam logic [Y_WIDTH-1:0] V_LO  = Y_WIDTH'(V_TOP);
    localparam logic [Y_WIDTH-1:0] V_HI  = Y_WIDTH'(V_TOP + SCREEN_HIGHT);

    cap_state_e         state_r;
    logic               frame_ok_r;
    logic               hs_r;
    logic               vs_r;
    logic [2:0]         rgb_r;
    logic [X_WIDTH-1:0] h_cnt_r;
    logic [Y_WIDTH-1:0] v_cnt_r;
    logic               v_pend_r;

    logic               h_rise_s;
    logic               h_fail_s;
    logic               v_rise_s;
    logic               v_fail_s;
    logic [X_WIDTH-1:0] h_cnt_nxt_s;
    logic [Y_WIDTH-1:0] v_cnt_nxt_s;
    logic               v_pend_nxt_s;
    logic               fail_any_s;
    logic               sat_s;
    logic               lock_nxt_s;
    logic               active_s;
    logic               pix_nxt_s;
    logic [X_WIDTH-1:0] x_nxt_s;
    logic [Y_WIDTH-1:0] y_nxt_s;

    game_sync_checker #(
        .CNT_W     (16),
        .LOW_WIDTH (H_SYNC),
        .PERIOD    (H_TOT)
    ) u_hsync_chk (
        .clk        (clk),
        .rst_n      (reset),
        .sync_level (hs_r),
        .tick       (1'b1),
        .rise_s     (h_rise_s),
        .fail_s     (h_fail_s)
    );

    game_sync_checker #(
        .CNT_W     (16),
        .LOW_WIDTH (0),
        .PERIOD    (V_TOT)
    ) u_vsync_chk (
        .clk        (clk),
        .rst_n      (reset),
        .sync_level (vs_r),
        .tick       (h_rise_s),
        .rise_s     (v_rise_s),
        .fail_s     (v_fail_s)
    );

    // Next beam position; a vsync edge is remembered until the line start that follows it.
    always_comb begin
        h_cnt_nxt_s  = h_cnt_r;
        v_cnt_nxt_s  = v_cnt_r;
        v_pend_nxt_s = v_pend_r;
        if (h_rise_s) begin
            h_cnt_nxt_s = {X_WIDTH{1'b0}};
        end else if (h_cnt_r != H_MAX) begin
            h_cnt_nxt_s = h_cnt_r + {{(X_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            h_cnt_nxt_s = h_cnt_r;
        end
        if (h_rise_s) begin
            v_pend_nxt_s = 1'b0;
            if (v_pend_r || v_rise_s) begin
                v_cnt_nxt_s = {Y_WIDTH{1'b0}};
            end else if (v_cnt_r != V_MAX) begin
                v_cnt_nxt_s = v_cnt_r + {{(Y_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                v_cnt_nxt_s = v_cnt_r;
            end
        end else if (v_rise_s) begin
            v_pend_nxt_s = 1'b1;
        end else begin
            v_pend_nxt_s = v_pend_r;
        end
    end

    // Lock decision and pixel qualification; a failure wins over a coincident vsync edge.
    always_comb begin
        fail_any_s = h_fail_s | v_fail_s;
        sat_s      = (h_cnt_nxt_s == H_MAX) | (v_cnt_nxt_s == V_MAX);
        case (state_r)
            MEASURE: lock_nxt_s = v_rise_s & frame_ok_r & ~fail_any_s;
            LOCKED:  lock_nxt_s = ~fail_any_s & ~sat_s;
            default: lock_nxt_s = 1'b0;
        endcase
        active_s  = (h_cnt_nxt_s >= H_LO) && (h_cnt_nxt_s < H_HI) &&
                    (v_cnt_nxt_s >= V_LO) && (v_cnt_nxt_s < V_HI);
        pix_nxt_s = lock_nxt_s & active_s;
        x_nxt_s   = h_cnt_nxt_s - H_LO;
        y_nxt_s   = v_cnt_nxt_s - V_LO;
    end

    // Input sampling and beam counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
            rgb_r    <= 3'd0;
            h_cnt_r  <= {X_WIDTH{1'b0}};
            v_cnt_r  <= {Y_WIDTH{1'b0}};
            v_pend_r <= 1'b0;
        end else begin
            hs_r     <= hsync;
            vs_r     <= vsync;
            rgb_r    <= rgb;
            h_cnt_r  <= h_cnt_nxt_s;
            v_cnt_r  <= v_cnt_nxt_s;
            v_pend_r <= v_pend_nxt_s;
        end
    end

    // Lock FSM with all module outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= SEARCH;
            frame_ok_r  <= 1'b0;
            pixel_valid <= 1'b0;
            x           <= {X_WIDTH{1'b0}};
            y           <= {Y_WIDTH{1'b0}};
            rgb_out     <= 3'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= pix_nxt_s;
            x           <= pix_nxt_s ? x_nxt_s : {X_WIDTH{1'b0}};
            y           <= pix_nxt_s ? y_nxt_s : {Y_WIDTH{1'b0}};
            rgb_out     <= pix_nxt_s ? rgb_r : 3'd0;
            frame_start <= pix_nxt_s && (x_nxt_s == {X_WIDTH{1'b0}}) &&
                           (y_nxt_s == {Y_WIDTH{1'b0}});
            locked      <= lock_nxt_s;
            error       <= 1'b0;
            case (state_r)
                SEARCH: begin
                    if (v_rise_s) begin
                        state_r    <= MEASURE;
                        frame_ok_r <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (v_rise_s) begin
                        // Frame boundary: either lock or restart the frame's checks.
                        state_r    <= lock_nxt_s ? LOCKED : MEASURE;
                        frame_ok_r <= 1'b1;
                    end else if (fail_any_s) begin
                        frame_ok_r <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (!lock_nxt_s) begin
                        state_r    <= SEARCH;
                        frame_ok_r <= 1'b0;
                        error      <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= SEARCH;
                    frame_ok_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_vga_capture.sv
// Scoreboard bench for game_vga_capture using a reduced raster (25 clocks x 13 lines).
// The generator pushes expected pixels as it drives them; a monitor pops on pixel_valid.
module tb_game_vga_capture;

    localparam int XW = 6;
    localparam int YW = 5;
    localparam int SW = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int SH = 8;
    localparam int VB = 1;
    localparam int VS = 2;
    localparam int VT = 2;
    localparam int HT = SW + HF + HS + HB;
    localparam int VTOT = SH + VB + VS + VT;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    rgb;
        logic          fs;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic [2:0]    rgb = 3'd0;
    logic          pixel_valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    rgb_out;
    logic          frame_start;
    logic          locked;
    logic          error;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   err_cnt = 0;
    int   lock_rises = 0;
    int   valid_cnt = 0;
    int   bad_idle = 0;
    int   last_lock_cyc = -1;
    int   last_unlock_cyc = -1;
    int   last_err_cyc = -1;
    int   last_vrise_cyc = -1;
    int   fail_cyc = -1;
    logic locked_q = 1'b0;
    pix_t sb_q[$];

    game_vga_capture #(
        .X_WIDTH(XW), .Y_WIDTH(YW),
        .SCREEN_WIDTH(SW), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .SCREEN_HIGHT(SH), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pixel_valid(pixel_valid), .x(x), .y(y), .rgb_out(rgb_out),
        .frame_start(frame_start), .locked(locked), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every presented pixel and tracks lock/error events.
    always @(negedge clk) begin
        pix_t e;
        pix_t g;
        if (pixel_valid) begin
            valid_cnt++;
            n_cmp++;
            g = '{x: x, y: y, rgb: rgb_out, fs: frame_start};
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d with no pixel expected", x, y);
            end else begin
                e = sb_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got x=%0d y=%0d rgb=%0d fs=%0d expected x=%0d y=%0d rgb=%0d fs=%0d",
                             g.x, g.y, g.rgb, g.fs, e.x, e.y, e.rgb, e.fs);
                end
            end
        end else if (rgb_out != 3'd0 || frame_start) begin
            bad_idle++;
        end
        if (error) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (locked && !locked_q) begin
            lock_rises++;
            last_lock_cyc = cyc;
        end
        if (!locked && locked_q) last_unlock_cyc = cyc;
        locked_q = locked;
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_pixel_valid"}, pixel_valid, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_rgb_out"}, rgb_out, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb   = 3'd0;
        #1;
        check_outputs_zero(tag);
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        locked_q = 1'b0;
    endtask

    task automatic gen_frame(input int lines, input int hs_low, input int stretch_line,
                             input int push_until, input int rst_line, input int rst_h);
        int len;
        logic act;
        logic [XW-1:0] xe;
        logic [YW-1:0] ye;
        pix_t e;
        for (int v = 0; v < lines; v++) begin
            len = (v == stretch_line) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                if (v == rst_line && h == rst_h) begin
                    async_reset("midline_reset");
                    return;
                end
                @(posedge clk);
                #1;
                if ((v < lines - VS) && !vsync) last_vrise_cyc = cyc;
                if (h == 0 && v == stretch_line + 1) fail_cyc = cyc;
                hsync = (h < len - hs_low);
                vsync = (v < lines - VS);
                act = (h >= HB) && (h < HB + SW) && (v >= VT) && (v < VT + SH);
                xe = XW'(h - HB);
                ye = YW'(v - VT);
                rgb = act ? (xe[2:0] ^ ye[2:0]) : 3'd0;
                if (act && v < push_until) begin
                    e = '{x: xe, y: ye, rgb: xe[2:0] ^ ye[2:0], fs: (h == HB && v == VT)};
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!vsync) last_vrise_cyc = cyc;
            hsync = 1'b1;
            vsync = 1'b1;
            rgb   = 3'd0;
        end
    endtask

    initial begin
        #3;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Initial lock: MEASURE from the first vsync edge, LOCKED at the second.
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        chk("no_lock_before_second_edge", lock_rises, 0);
        gen_frame(VTOT, HS, -1, 99, -1, -1);
        chk("lock_rises_first", lock_rises, 1);
        chk("lock_latency", last_lock_cyc - last_vrise_cyc, 2);
        valid_cnt = 0;
        gen_frame(VTOT, HS, -1, 99, -1, -1);
        chk("valid_per_frame", valid_cnt, SW * SH);

        // Stretched line 5: pixels until the next line start, then one error.
        gen_frame(VTOT, HS, 5, 6, -1, -1);
        chk("stretch_err_count", err_cnt, 1);
        chk("stretch_err_latency", last_err_cyc - fail_cyc, 2);
        chk("stretch_unlock_latency", last_unlock_cyc - fail_cyc, 2);
        chk("stretch_locked", locked, 0);
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        chk("no_relock_after_one_edge", lock_rises, 1);
        gen_frame(VTOT, HS, -1, 99, 4, 10);
        chk("relock_after_stretch", lock_rises, 2);
        chk("midline_reset_no_error", err_cnt, 1);

        // After mid-line reset: full SEARCH -> MEASURE -> LOCKED sequence again.
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        chk("no_early_relock_after_reset", lock_rises, 2);
        gen_frame(VTOT, HS, -1, 99, -1, -1);
        chk("relock_after_reset", lock_rises, 3);

        // Short frame: vsync period wrong, never locks, never errors.
        async_reset("short_frame_reset");
        for (int i = 0; i < 4; i++) gen_frame(VTOT - 1, HS, -1, 0, -1, -1);
        chk("short_frame_no_lock", lock_rises, 3);
        chk("short_frame_no_error", err_cnt, 1);

        // Narrow hsync: low width wrong, never locks, never errors.
        async_reset("narrow_hsync_reset");
        for (int i = 0; i < 4; i++) gen_frame(VTOT, HS - 1, -1, 0, -1, -1);
        chk("narrow_hsync_no_lock", lock_rises, 3);
        chk("narrow_hsync_no_error", err_cnt, 1);

        // hsync stuck high while locked: h_cnt saturates, single error.
        async_reset("stuck_reset");
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        gen_frame(VTOT, HS, -1, 0, -1, -1);
        gen_frame(VTOT, HS, -1, 99, -1, -1);
        chk("stuck_prelock", lock_rises, 4);
        hold_high(100);
        chk("stuck_err_count", err_cnt, 2);
        chk("stuck_locked", locked, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("idle_rgb_zero", bad_idle, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
